camera_init_sequencer: RTL and testbench

Power-up and bring-up controller that sits directly upstream of the camera configurator. It sequences the camera PWDN and RESET pins, then requests the register-load transfer through the configurator's valid/ready init handshake. It monitors the I2C bus-activity flag to detect completion or a stall, retries on timeout, and reports a sticky ready or error status to the video pipeline.

---
 rtl/camera_init_sequencer.sv | 160 ++++++++++++++++
 tb/tb_camera_init_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_init_sequencer.sv
// Camera power-up sequencer: drives PWDN/RESET pins, requests the register load from the
// configurator, watches I2C activity for completion, retries on timeout, reports status.
module camera_init_sequencer #(
  parameter int unsigned PWDN_CYCLES    = 2_000_000,
  parameter int unsigned RESET_CYCLES   = 2_000_000,
  parameter int unsigned SETTLE_CYCLES  = 4_000_000,
  parameter int unsigned QUIET_CYCLES   = 100_000,
  parameter int unsigned TIMEOUT_CYCLES = 400_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                               clk_camera,
  input  logic                               sys_rst_camera,
  input  logic                               start,
  output logic                               cam_pwdn,
  output logic                               cam_reset_n,
  output logic                               cr_init_valid,
  input  logic                               cr_init_ready,
  input  logic                               bus_active,
  output logic                               cam_ready,
  output logic                               cfg_error,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int unsigned Max01 = (PWDN_CYCLES > RESET_CYCLES) ? PWDN_CYCLES : RESET_CYCLES;
  localparam int unsigned Max23 = (SETTLE_CYCLES > QUIET_CYCLES) ? SETTLE_CYCLES : QUIET_CYCLES;
  localparam int unsigned PhaseMax = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned PW = $clog2(PhaseMax + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] PwdnLast   = PW'(PWDN_CYCLES - 1);
  localparam logic [PW-1:0] ResetLast  = PW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] SettleLast = PW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] QuietLast  = PW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0] ToLast     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RetryMax   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle, StPwdn, StRst, StSettle, StReq, StRun, StDone, StFail
  } state_e;

  state_e        state_q;
  logic [PW-1:0] phase_q;
  logic [TW-1:0] to_q;
  logic [RW-1:0] retry_q;
  logic          seen_q, auto_q;
  logic          pwdn_q, reset_n_q, valid_q, ready_q, error_q;

  always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
    if (sys_rst_camera) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      to_q      <= '0;
      retry_q   <= '0;
      seen_q    <= 1'b0;
      auto_q    <= AUTO_START;
      pwdn_q    <= 1'b1;
      reset_n_q <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start || auto_q) begin
            auto_q  <= 1'b0;
            state_q <= StPwdn;
            phase_q <= '0;
          end
        end
        StPwdn: begin
          if (phase_q == PwdnLast) begin
            state_q <= StRst;
            phase_q <= '0;
            pwdn_q  <= 1'b0;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        StRst: begin
          if (phase_q == ResetLast) begin
            state_q   <= StSettle;
            phase_q   <= '0;
            reset_n_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        StSettle: begin
          if (phase_q == SettleLast) begin
            state_q <= StReq;
            phase_q <= '0;
            to_q    <= '0;
            valid_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        StReq, StRun: begin
          // Timeout wins over a transfer or quiet completion on the same cycle.
          if (to_q == ToLast) begin
            valid_q   <= 1'b0;
            pwdn_q    <= 1'b1;
            reset_n_q <= 1'b0;
            phase_q   <= '0;
            if (retry_q < RetryMax) begin
              retry_q <= retry_q + RW'(1);
              state_q <= StPwdn;
            end else begin
              error_q <= 1'b1;
              state_q <= StFail;
            end
          end else begin
            to_q <= to_q + TW'(1);
            if (state_q == StReq) begin
              if (cr_init_ready) begin
                valid_q <= 1'b0;
                seen_q  <= 1'b0;
                phase_q <= '0;
                state_q <= StRun;
              end
            end else if (bus_active) begin
              seen_q  <= 1'b1;
              phase_q <= '0;
            end else if (seen_q) begin
              if (phase_q == QuietLast) begin
                ready_q   <= 1'b1;
                pwdn_q    <= 1'b0;
                reset_n_q <= 1'b1;
                state_q   <= StDone;
              end else begin
                phase_q <= phase_q + PW'(1);
              end
            end
          end
        end
        StDone, StFail: begin
          if (start) begin
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            retry_q   <= '0;
            pwdn_q    <= 1'b1;
            reset_n_q <= 1'b0;
            phase_q   <= '0;
            state_q   <= StPwdn;
          end
        end
      endcase
    end
  end

  assign cam_pwdn      = pwdn_q;
  assign cam_reset_n   = reset_n_q;
  assign cr_init_valid = valid_q;
  assign cam_ready     = ready_q;
  assign cfg_error     = error_q;
  assign retry_count   = retry_q;

endmodule

// File: tb/tb_camera_init_sequencer.sv
// Bench for camera_init_sequencer: scenario table, hand-written corner sequences and random
// stimulus, all checked every cycle against an elapsed-time reference model.
module tb_camera_init_sequencer;

  localparam int PWDN    = 4;
  localparam int RSTC    = 3;
  localparam int SETTLE  = 5;
  localparam int QUIET   = 8;
  localparam int TIMEOUT = 100;
  localparam int MAXR    = 2;
  localparam int W       = PWDN + RSTC + SETTLE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cr_init_ready = 1'b0;
  logic bus_active = 1'b0;
  logic cam_pwdn, cam_reset_n, cr_init_valid, cam_ready, cfg_error;
  logic [1:0] retry_count;

  int checks = 0;
  int failures = 0;

  // Reference model: progress is time elapsed since the current sequence began.
  bit m_active, m_done, m_fail, m_auto, m_xferred, m_seen;
  int m_t, m_idle, m_retry, m_xfer_edge;
  int edge_cnt = 0;

  typedef struct {
    string name;
    int    hold;
    int    d;
    int    h1;
    int    gap;
    int    h2;
    bit    stall;
    bit    exp_rdy;
    bit    exp_err;
    int    exp_retry;
    int    exp_valid;
    int    exp_k;
    int    exp_req;
    int    maxc;
  } scen_t;

  scen_t tbl[4];

  camera_init_sequencer #(
    .PWDN_CYCLES   (PWDN),
    .RESET_CYCLES  (RSTC),
    .SETTLE_CYCLES (SETTLE),
    .QUIET_CYCLES  (QUIET),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES   (MAXR),
    .AUTO_START    (1'b1)
  ) dut (
    .clk_camera    (clk),
    .sys_rst_camera(rst),
    .start         (start),
    .cam_pwdn      (cam_pwdn),
    .cam_reset_n   (cam_reset_n),
    .cr_init_valid (cr_init_valid),
    .cr_init_ready (cr_init_ready),
    .bus_active    (bus_active),
    .cam_ready     (cam_ready),
    .cfg_error     (cfg_error),
    .retry_count   (retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_fail = 0; m_auto = 1;
    m_xferred = 0; m_seen = 0; m_t = 0; m_idle = 0; m_retry = 0;
  endtask

  task automatic begin_seq();
    m_active = 1; m_t = 0; m_xferred = 0; m_seen = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit st, input bit rdy, input bit bus);
    edge_cnt++;
    if (rst) begin
      model_reset();
    end else if (m_done || m_fail) begin
      if (st) begin
        m_done = 0; m_fail = 0; m_retry = 0;
        begin_seq();
      end
    end else if (!m_active) begin
      if (st || m_auto) begin
        m_auto = 0;
        begin_seq();
      end
    end else if (m_t < W) begin
      m_t++;
    end else if (m_t - W + 1 == TIMEOUT) begin
      if (m_retry < MAXR) begin
        m_retry++;
        begin_seq();
      end else begin
        m_active = 0;
        m_fail = 1;
      end
    end else begin
      if (!m_xferred) begin
        if (rdy) begin
          m_xferred = 1; m_seen = 0; m_idle = 0; m_xfer_edge = edge_cnt;
        end
      end else if (bus) begin
        m_seen = 1; m_idle = 0;
      end else if (m_seen) begin
        m_idle++;
        if (m_idle == QUIET) begin
          m_active = 0;
          m_done = 1;
        end
      end
      m_t++;
    end
  endtask

  // {pwdn, reset_n, valid, ready, error, retry[1:0]}
  function automatic logic [6:0] model_exp();
    logic [1:0] r;
    r = 2'(m_retry);
    if (m_done)        return {5'b01010, r};
    else if (m_fail)   return {5'b10001, r};
    else if (!m_active) return {5'b10000, r};
    return {(m_t < PWDN), (m_t >= PWDN + RSTC), (m_t >= W && !m_xferred), 2'b00, r};
  endfunction

  function automatic logic [6:0] outs();
    return {cam_pwdn, cam_reset_n, cr_init_valid, cam_ready, cfg_error, retry_count};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step(start, cr_init_ready, bus_active);
    @(negedge clk);
    check($sformatf("cycle%0d", edge_cnt), 32'(outs()), 32'(model_exp()));
  endtask

  task automatic drive(input scen_t s);
    int k;
    start = 1'b0;
    cr_init_ready = 1'b0;
    bus_active = 1'b0;
    if (m_active && m_t >= W && !m_xferred) cr_init_ready = ((m_t - W) >= s.hold);
    if (m_active && m_xferred && !s.stall) begin
      k = edge_cnt + 1 - m_xfer_edge;
      bus_active = (k >= s.d && k < s.d + s.h1) ||
                   (s.gap > 0 && k >= s.d + s.h1 + s.gap && k < s.d + s.h1 + s.gap + s.h2);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cr_init_ready = 1'b0; bus_active = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic run(input scen_t s, input int settle_start, output int valid_hi,
                     output int done_k, output int req_lat, output bit finished);
    int n;
    bit used;
    n = 0; used = 0;
    valid_hi = 0; done_k = -1; req_lat = -1; finished = 0;
    while (!finished && n < s.maxc) begin
      drive(s);
      if (settle_start >= 0 && !used && m_active && m_t == settle_start) begin
        start = 1'b1;
        used = 1;
      end
      step();
      n++;
      if (cr_init_valid === 1'b1) begin
        valid_hi++;
        if (req_lat < 0) req_lat = n;
      end
      if (cam_ready === 1'b1 && done_k < 0) done_k = edge_cnt - m_xfer_edge;
      if (m_done || m_fail) finished = 1;
    end
    repeat (3) begin
      drive(s);
      step();
      if (cam_ready === 1'b1 && done_k < 0) done_k = edge_cnt - m_xfer_edge;
    end
    check({s.name, ".bound"}, 32'(finished), 32'd1);
  endtask

  initial begin
    int vh, dk, rl, n, rp, gp, burst;
    bit fin;
    //          name        hold d  h1 gap h2 stall rdy err rtry vld k   req maxc
    tbl[0] = '{"happy",     0,   2, 20, 0, 0, 0,    1,  0,  0,   1,  29, 13, 200};
    tbl[1] = '{"backpress", 10,  2, 20, 0, 0, 0,    1,  0,  0,   11, 29, 12, 200};
    tbl[2] = '{"glitch",    0,   2, 6,  5, 4, 0,    1,  0,  0,   1,  24, 12, 200};
    tbl[3] = '{"stall",     0,   0, 0,  0, 0, 1,    0,  1,  2,   3,  -1, 12, 600};
    model_reset();
    burst = 0; rp = 1; gp = 8;

    repeat (3) step();
    rst = 1'b0;
    check("reset.outputs", 32'(outs()), 32'(7'b1000000));

    for (int i = 0; i < 4; i++) begin
      if (i > 0) pulse_start();
      run(tbl[i], -1, vh, dk, rl, fin);
      check({tbl[i].name, ".cam_ready"}, 32'(cam_ready), 32'(tbl[i].exp_rdy));
      check({tbl[i].name, ".cfg_error"}, 32'(cfg_error), 32'(tbl[i].exp_err));
      check({tbl[i].name, ".retry"}, 32'(retry_count), 32'(tbl[i].exp_retry));
      check({tbl[i].name, ".valid_cycles"}, 32'(vh), 32'(tbl[i].exp_valid));
      check({tbl[i].name, ".req_latency"}, 32'(rl), 32'(tbl[i].exp_req));
      check({tbl[i].name, ".done_latency"}, 32'(dk), 32'(tbl[i].exp_k));
    end
    check("stall.fail_pwdn", 32'(cam_pwdn), 32'd1);

    // Restart from FAIL, with an extra start pulse during SETTLE that must be ignored.
    pulse_start();
    check("restart_fail.err_clear", 32'(cfg_error), 32'd0);
    check("restart_fail.retry_clear", 32'(retry_count), 32'd0);
    run(tbl[0], PWDN + RSTC + 1, vh, dk, rl, fin);
    check("settle_start.req_latency", 32'(rl), 32'd12);
    check("settle_start.done_latency", 32'(dk), 32'd29);
    check("settle_start.cam_ready", 32'(cam_ready), 32'd1);

    // Restart from DONE, then async reset mid-RUN while the bus is busy.
    pulse_start();
    check("restart_done.ready_clear", 32'(cam_ready), 32'd0);
    n = 0;
    while (!(m_xferred && edge_cnt - m_xfer_edge >= 6) && n < 100) begin
      drive(tbl[0]);
      step();
      n++;
    end
    check("async.reached_run", 32'(m_xferred), 32'd1);
    #2 rst = 1'b1;
    #1 model_reset();
    check("async.immediate", 32'(outs()), 32'(7'b1000000));
    start = 1'b0; cr_init_ready = 1'b0; bus_active = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    run(tbl[0], -1, vh, dk, rl, fin);
    check("async.restart_req_latency", 32'(rl), 32'd13);
    check("async.restart_done_latency", 32'(dk), 32'd29);
    check("async.restart_ready", 32'(cam_ready), 32'd1);

    // Random traffic: stray starts, bursty bus, varying backpressure (rp=0 never ready).
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        rp = int'($urandom_range(0, 3));
        gp = int'($urandom_range(2, 16));
      end
      start = ($urandom_range(0, 59) == 0);
      cr_init_ready = (rp != 0) && ($urandom_range(1, rp) == 1);
      if (burst > 0) burst--;
      else if ($urandom_range(1, gp) == 1) burst = int'($urandom_range(1, 5));
      bus_active = (burst > 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
